// File: rtl/e203_ifu_jalr_sched_pkg.sv
// Shared types and defaults for the IFU JALR target scheduler.
package e203_ifu_jalr_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DEP  = 2'd1,
    ST_RD   = 2'd2,
    ST_RSP  = 2'd3
  } jalr_state_e;

  localparam int DBG_STARVE_DEF = 8;

  // Counter width able to hold 0..n; never narrower than one bit.
  function automatic int starve_cw(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/e203_ifu_rfrd_arb.sv
// Two-requester regfile read-port arbiter: JALR has priority until debug has
// waited DBG_STARVE cycles, then debug wins once.
module e203_ifu_rfrd_arb
  import e203_ifu_jalr_sched_pkg::*;
#(
  parameter int RFIDX_WIDTH = 5,
  parameter int DBG_STARVE  = DBG_STARVE_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   jalr_req,
  input  logic [RFIDX_WIDTH-1:0] jalr_idx,
  input  logic                   dbg_req,
  input  logic [RFIDX_WIDTH-1:0] dbg_idx,
  output logic                   jalr_gnt,
  output logic                   dbg_gnt,
  output logic                   rd_ena,
  output logic [RFIDX_WIDTH-1:0] rd_idx
);

  localparam int CW = starve_cw(DBG_STARVE);

  logic [CW-1:0] cnt;
  logic          starved;

  assign starved  = (cnt == CW'(DBG_STARVE));
  assign dbg_gnt  = dbg_req & (~jalr_req | starved);
  assign jalr_gnt = jalr_req & ~dbg_gnt;
  assign rd_ena   = dbg_gnt | jalr_gnt;
  assign rd_idx   = dbg_gnt ? dbg_idx : jalr_idx;

  always_ff @(posedge clk) begin
    if (rst)                      cnt <= '0;
    else if (dbg_gnt)             cnt <= '0;
    else if (dbg_req && !starved) cnt <= cnt + CW'(1);
  end

endmodule

// File: rtl/e203_ifu_jalr_sched.sv
// JALR register-indirect target scheduler: waits out rs1 hazards, reads rs1
// through the shared regfile port and pulses the computed target PC.
module e203_ifu_jalr_sched
  import e203_ifu_jalr_sched_pkg::*;
#(
  parameter int PC_SIZE     = 32,
  parameter int XLEN        = 32,
  parameter int RFIDX_WIDTH = 5,
  parameter int DBG_STARVE  = DBG_STARVE_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   jreq_valid,
  output logic                   jreq_ready,
  input  logic [RFIDX_WIDTH-1:0] jreq_rs1idx,
  input  logic [XLEN-1:0]        jreq_imm,
  input  logic                   oitf_empty,
  input  logic                   ir_empty,
  input  logic                   ir_valid_clr,
  input  logic                   ir_rdwen,
  input  logic [RFIDX_WIDTH-1:0] ir_rdidx,
  input  logic                   flush,
  input  logic                   dbg_req_valid,
  output logic                   dbg_req_ready,
  input  logic [RFIDX_WIDTH-1:0] dbg_req_idx,
  output logic                   dbg_rsp_valid,
  output logic [XLEN-1:0]        dbg_rsp_data,
  output logic                   rf_rd_ena,
  output logic [RFIDX_WIDTH-1:0] rf_rd_idx,
  input  logic [XLEN-1:0]        rf_rd_data,
  output logic                   bpu_wait,
  output logic                   tgt_valid,
  output logic [PC_SIZE-1:0]     tgt_pc
);

  jalr_state_e            state_q, state_d;
  logic [RFIDX_WIDTH-1:0] rs1_q;
  logic [XLEN-1:0]        imm_q, data_q;
  logic                   dbg_rsp_q;
  logic                   dep_clr, jalr_req, jalr_gnt, dbg_gnt, hsk;

  assign dep_clr  = oitf_empty & (ir_empty | ir_valid_clr | ~(ir_rdwen & (ir_rdidx == rs1_q)));
  // A flush cycle withdraws the JALR from arbitration so no stale read issues.
  assign jalr_req = (state_q == ST_DEP) & dep_clr & ~flush;
  assign hsk      = jreq_valid & jreq_ready;

  e203_ifu_rfrd_arb #(
    .RFIDX_WIDTH (RFIDX_WIDTH),
    .DBG_STARVE  (DBG_STARVE)
  ) u_arb (
    .clk      (clk),
    .rst      (rst),
    .jalr_req (jalr_req),
    .jalr_idx (rs1_q),
    .dbg_req  (dbg_req_valid),
    .dbg_idx  (dbg_req_idx),
    .jalr_gnt (jalr_gnt),
    .dbg_gnt  (dbg_gnt),
    .rd_ena   (rf_rd_ena),
    .rd_idx   (rf_rd_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (hsk) state_d = (jreq_rs1idx == '0) ? ST_RSP : ST_DEP;
      ST_DEP:  if (flush) state_d = ST_IDLE;
               else if (jalr_gnt) state_d = ST_RD;
      ST_RD:   state_d = flush ? ST_IDLE : ST_RSP;
      ST_RSP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    jreq_ready    = (state_q == ST_IDLE) & ~flush;
    bpu_wait      = (state_q != ST_IDLE);
    tgt_valid     = (state_q == ST_RSP) & ~flush;
    tgt_pc        = (state_q == ST_RSP) ? (data_q[PC_SIZE-1:0] + imm_q[PC_SIZE-1:0]) : '0;
    dbg_req_ready = dbg_gnt;
    dbg_rsp_valid = dbg_rsp_q;
    dbg_rsp_data  = dbg_rsp_q ? rf_rd_data : '0;
  end

  // x0 requests preload zero so RSP can form the target without a read.
  always_ff @(posedge clk) begin
    if (rst) begin
      rs1_q     <= '0;
      imm_q     <= '0;
      data_q    <= '0;
      dbg_rsp_q <= 1'b0;
    end else begin
      dbg_rsp_q <= dbg_gnt;
      if (hsk) begin
        rs1_q  <= jreq_rs1idx;
        imm_q  <= jreq_imm;
        data_q <= '0;
      end else if (state_q == ST_RD) begin
        data_q <= rf_rd_data;
      end
    end
  end

endmodule

// File: tb/tb_e203_ifu_jalr_sched.sv
// Random-stimulus bench for e203_ifu_jalr_sched against a transaction-level model.
module tb_e203_ifu_jalr_sched;
  localparam int PC_SIZE = 32, XLEN = 32, RW = 5, STARVE = 8;

  logic clk = 1'b0;
  logic rst;
  logic jreq_valid, jreq_ready;
  logic [RW-1:0] jreq_rs1idx;
  logic [XLEN-1:0] jreq_imm;
  logic oitf_empty, ir_empty, ir_valid_clr, ir_rdwen;
  logic [RW-1:0] ir_rdidx;
  logic flush;
  logic dbg_req_valid, dbg_req_ready;
  logic [RW-1:0] dbg_req_idx;
  logic dbg_rsp_valid;
  logic [XLEN-1:0] dbg_rsp_data;
  logic rf_rd_ena;
  logic [RW-1:0] rf_rd_idx;
  logic [XLEN-1:0] rf_rd_data = '0;
  logic bpu_wait, tgt_valid;
  logic [PC_SIZE-1:0] tgt_pc;

  always #5 clk = ~clk;

  e203_ifu_jalr_sched #(
    .PC_SIZE(PC_SIZE), .XLEN(XLEN), .RFIDX_WIDTH(RW), .DBG_STARVE(STARVE)
  ) dut (
    .clk(clk), .rst(rst),
    .jreq_valid(jreq_valid), .jreq_ready(jreq_ready),
    .jreq_rs1idx(jreq_rs1idx), .jreq_imm(jreq_imm),
    .oitf_empty(oitf_empty), .ir_empty(ir_empty), .ir_valid_clr(ir_valid_clr),
    .ir_rdwen(ir_rdwen), .ir_rdidx(ir_rdidx), .flush(flush),
    .dbg_req_valid(dbg_req_valid), .dbg_req_ready(dbg_req_ready), .dbg_req_idx(dbg_req_idx),
    .dbg_rsp_valid(dbg_rsp_valid), .dbg_rsp_data(dbg_rsp_data),
    .rf_rd_ena(rf_rd_ena), .rf_rd_idx(rf_rd_idx), .rf_rd_data(rf_rd_data),
    .bpu_wait(bpu_wait), .tgt_valid(tgt_valid), .tgt_pc(tgt_pc)
  );

  // Regfile stand-in: one-cycle read latency.
  logic [XLEN-1:0] rf [32];
  always @(posedge clk) if (rf_rd_ena) rf_rd_data <= rf[rf_rd_idx];

  int errs = 0, checks = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: one outstanding JALR tracked as "waiting on rs1",
  // "read in flight" or "target due", plus the debug wait count.
  bit m_busy, m_dep, m_rd, m_fire, m_dpend;
  logic [RW-1:0] m_idx;
  logic [XLEN-1:0] m_imm, m_data, m_ddata;
  int m_cnt;

  logic [XLEN-1:0] imm_tab [4];

  // mode 0: fully random; mode 1: JALR always clear, debug only when JALR contends
  task automatic do_cycle(input int mode);
    bit clear, want, dwin, jwin;
    logic [XLEN-1:0] sum;
    @(negedge clk);
    rst          = (mode == 0) && ($urandom_range(0, 79) == 0);
    jreq_valid   = (mode == 1) || ($urandom_range(0, 2) != 0);
    jreq_rs1idx  = (mode == 1) ? RW'($urandom_range(1, 7))
                 : (($urandom_range(0, 3) == 0) ? '0 : RW'($urandom_range(1, 7)));
    jreq_imm     = imm_tab[$urandom_range(0, 3)];
    oitf_empty   = (mode == 1) || ($urandom_range(0, 4) != 0);
    ir_empty     = (mode == 1) || ($urandom_range(0, 1) == 1);
    ir_valid_clr = ($urandom_range(0, 3) == 0);
    ir_rdwen     = ($urandom_range(0, 1) == 1);
    ir_rdidx     = RW'($urandom_range(0, 7));
    flush        = (mode == 0) && ($urandom_range(0, 15) == 0);
    dbg_req_idx  = RW'($urandom_range(0, 31));
    clear = oitf_empty && (ir_empty || ir_valid_clr || !(ir_rdwen && ir_rdidx == m_idx));
    want  = m_dep && clear && !flush;
    dbg_req_valid = (mode == 1) ? want : ($urandom_range(0, 3) == 0);
    #1;
    dwin = dbg_req_valid && (!want || m_cnt >= STARVE);
    jwin = want && !dwin;
    sum  = m_data + m_imm;
    chk("jreq_ready", jreq_ready, !m_busy && !flush);
    chk("bpu_wait", bpu_wait, m_busy);
    chk("rf_rd_ena", rf_rd_ena, dwin || jwin);
    if (dwin || jwin) chk("rf_rd_idx", rf_rd_idx, dwin ? dbg_req_idx : m_idx);
    chk("dbg_req_ready", dbg_req_ready, dwin);
    chk("tgt_valid", tgt_valid, m_fire && !flush);
    chk("tgt_pc", tgt_pc, m_fire ? sum : '0);
    chk("dbg_rsp_valid", dbg_rsp_valid, m_dpend);
    chk("dbg_rsp_data", dbg_rsp_data, m_dpend ? m_ddata : '0);
    @(posedge clk);
    if (rst) begin
      {m_busy, m_dep, m_rd, m_fire, m_dpend} = '0;
      m_cnt = 0;
    end else begin
      m_dpend = dwin;
      if (dwin) m_ddata = rf[dbg_req_idx];
      if (dwin) m_cnt = 0;
      else if (dbg_req_valid && m_cnt < STARVE) m_cnt++;
      if (m_busy && flush) begin
        {m_busy, m_dep, m_rd, m_fire} = '0;
      end else if (m_fire) begin
        m_fire = 0; m_busy = 0;
      end else if (m_rd) begin
        m_rd = 0; m_data = rf[m_idx]; m_fire = 1;
      end else if (m_dep) begin
        if (jwin) begin m_dep = 0; m_rd = 1; end
      end else if (!m_busy && jreq_valid && !flush) begin
        m_busy = 1; m_idx = jreq_rs1idx; m_imm = jreq_imm;
        if (jreq_rs1idx == '0) begin m_data = '0; m_fire = 1; end
        else m_dep = 1;
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    rf[0] = '0;
    rf[5] = 32'h0000_2000;
    rf[7] = 32'hFFFF_FFF0;
    imm_tab[0] = 32'h0000_0100;
    imm_tab[1] = 32'hFFFF_FFFC;
    imm_tab[2] = 32'h0000_0020;
    imm_tab[3] = $urandom;
    {jreq_valid, oitf_empty, ir_empty, ir_valid_clr, ir_rdwen, flush, dbg_req_valid} = '0;
    jreq_rs1idx = '0; jreq_imm = '0; ir_rdidx = '0; dbg_req_idx = '0;
    {m_busy, m_dep, m_rd, m_fire, m_dpend} = '0;
    m_cnt = 0; m_idx = '0; m_imm = '0; m_data = '0; m_ddata = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_jreq_ready", jreq_ready, 1'b1);
    chk("rst_bpu_wait", bpu_wait, 1'b0);
    chk("rst_tgt_valid", tgt_valid, 1'b0);
    chk("rst_tgt_pc", tgt_pc, '0);
    chk("rst_rf_rd_ena", rf_rd_ena, 1'b0);
    chk("rst_dbg_req_ready", dbg_req_ready, 1'b0);
    chk("rst_dbg_rsp_valid", dbg_rsp_valid, 1'b0);
    chk("rst_dbg_rsp_data", dbg_rsp_data, '0);
    repeat (1500) do_cycle(0);
    repeat (80) do_cycle(1);
    repeat (500) do_cycle(0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
